// File: rtl/fifo_pair_write_arbiter.sv
// Round-robin arbiter packing two producer beats into one FIFO write word.
// Optional partial-pair flush in HI is enabled by defining PAIR_FLUSH_EN.
module fifo_pair_write_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    req0_valid_i,
    input  logic [DATA_WIDTH-1:0]   req0_data_i,
    output logic                    req0_ready_o,
    input  logic                    req1_valid_i,
    input  logic [DATA_WIDTH-1:0]   req1_data_i,
    output logic                    req1_ready_o,
    input  logic                    fifo_full_i,
    output logic                    fifo_write_o,
    output logic [2*DATA_WIDTH-1:0] fifo_data_o,
    output logic [1:0]              grant_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LO    = 2'd1;
    localparam logic [1:0] HI    = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [2*DATA_WIDTH-1:0] data_q, data_d;
    logic                    last_owner_q, last_owner_d;

    logic                    owner_valid;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    beat_phase;
    logic                    owner_fire;
    logic                    write_fire;

    assign owner_valid = grant_q[0] ? req0_valid_i : req1_valid_i;
    assign owner_data  = grant_q[0] ? req0_data_i : req1_data_i;
    assign beat_phase  = (state_q == LO) || (state_q == HI);
    assign owner_fire  = beat_phase && owner_valid;
    assign write_fire  = (state_q == WRITE) && !fifo_full_i;

    assign req0_ready_o = beat_phase && grant_q[0];
    assign req1_ready_o = beat_phase && grant_q[1];
    assign fifo_write_o = write_fire;
    assign fifo_data_o  = data_q;
    assign grant_o      = grant_q;

`ifdef PAIR_FLUSH_EN
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_MAX = CW'(FLUSH_CYCLES);

    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          flush_hit;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q == LO) begin
            idle_cnt_d = '0;
        end else if (state_q == HI) begin
            if (owner_valid) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q != FLUSH_MAX) begin
                idle_cnt_d = idle_cnt_q + CW'(1);
            end
        end
    end

    assign flush_hit = (state_q == HI) && !owner_valid &&
                       (idle_cnt_d == FLUSH_MAX);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic flush_hit;
    assign flush_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        data_d       = data_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                // Tie goes to whoever did not own the previous pair.
                if (req0_valid_i && req1_valid_i) begin
                    grant_d = last_owner_q ? 2'b01 : 2'b10;
                    state_d = LO;
                end else if (req0_valid_i) begin
                    grant_d = 2'b01;
                    state_d = LO;
                end else if (req1_valid_i) begin
                    grant_d = 2'b10;
                    state_d = LO;
                end
            end
            LO: begin
                if (owner_fire) begin
                    data_d[DATA_WIDTH-1:0] = owner_data;
                    state_d = HI;
                end
            end
            HI: begin
                if (owner_fire) begin
                    data_d[2*DATA_WIDTH-1:DATA_WIDTH] = owner_data;
                    state_d = WRITE;
                end else if (flush_hit) begin
                    data_d[2*DATA_WIDTH-1:DATA_WIDTH] = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (write_fire) begin
                    last_owner_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            data_q       <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_fifo_pair_write_arbiter.sv
// Scoreboard bench for fifo_pair_write_arbiter.
module tb_fifo_pair_write_arbiter;

    localparam int DW = 8;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [1:0]      gnt;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          req0_valid_i = 1'b0;
    logic [DW-1:0] req0_data_i = '0;
    logic          req0_ready_o;
    logic          req1_valid_i = 1'b0;
    logic [DW-1:0] req1_data_i = '0;
    logic          req1_ready_o;
    logic          fifo_full_i = 1'b0;
    logic          fifo_write_o;
    logic [2*DW-1:0] fifo_data_o;
    logic [1:0]    grant_o;

    fifo_pair_write_arbiter #(
        .DATA_WIDTH   (DW),
        .FLUSH_CYCLES (4)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_write_o (fifo_write_o),
        .fifo_data_o  (fifo_data_o),
        .grant_o      (grant_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nwrites = 0;
    int last_wr_cyc = 0;
    bit auto_drv = 1'b1;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        if (auto_drv) begin
            req0_valid_i = (q0.size() != 0);
            req0_data_i  = (q0.size() != 0) ? q0[0] : '0;
            req1_valid_i = (q1.size() != 0);
            req1_data_i  = (q1.size() != 0) ? q1[0] : '0;
        end
    endtask

    task automatic step();
        bit hs0, hs1;
        exp_t e;
        @(negedge clk_i);
        cyc++;
        hs0 = req0_valid_i && req0_ready_o;
        hs1 = req1_valid_i && req1_ready_o;
        if (fifo_write_o) begin
            nwrites++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(fifo_data_o), 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", 32'(fifo_data_o), 32'(e.data));
                chk("wr_grant", 32'(grant_o), 32'(e.gnt));
            end
        end
        @(posedge clk_i);
        #1;
        if (hs0 && q0.size() != 0) void'(q0.pop_front());
        if (hs1 && q1.size() != 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (nwrites < target && n < budget) begin
            step();
            n++;
        end
        chk("wr_count", 32'(nwrites), 32'(target));
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        q0.delete();
        q1.delete();
        step();
        step();
        reset_ni = 1'b1;
    endtask

    task automatic push_pair(input int p, input logic [DW-1:0] a,
                             input logic [DW-1:0] b);
        exp_t e;
        if (p == 0) begin
            q0.push_back(a);
            q0.push_back(b);
        end else begin
            q1.push_back(a);
            q1.push_back(b);
        end
        e.data = {b, a};
        e.gnt  = (p == 0) ? 2'b01 : 2'b10;
        exp_q.push_back(e);
    endtask

    initial begin
        int t0;
        int nw;
        exp_t e;

        // Reset held with both valids high
        auto_drv = 1'b0;
        reset_ni = 1'b0;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        req0_data_i  = 8'h77;
        req1_data_i  = 8'h88;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_grant", 32'(grant_o), 0);
            chk("rst_ready0", 32'(req0_ready_o), 0);
            chk("rst_ready1", 32'(req1_ready_o), 0);
            chk("rst_write", 32'(fifo_write_o), 0);
            chk("rst_data", 32'(fifo_data_o), 0);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        reset_ni = 1'b1;
        auto_drv = 1'b1;
        step();
        chk("idle_grant", 32'(grant_o), 0);

        // Single pair from producer 0, latency
        push_pair(0, 8'hA1, 8'hB2);
        t0 = cyc;
        drive();
        wait_writes(nwrites + 1, 20);
        chk("pair_latency", 32'(last_wr_cyc - t0), 4);
        step();
        chk("post_write_grant", 32'(grant_o), 0);

        // Fair alternation with both producers loaded
        do_reset();
        push_pair(0, 8'h10, 8'h11);
        push_pair(1, 8'h20, 8'h21);
        push_pair(0, 8'h12, 8'h13);
        push_pair(1, 8'h22, 8'h23);
        drive();
        wait_writes(nwrites + 4, 40);
        chk("rr_sb_empty", 32'(exp_q.size()), 0);

        // FIFO full held in WRITE
        fifo_full_i = 1'b1;
        push_pair(0, 8'h11, 8'h22);
        nw = nwrites;
        drive();
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("full_nowrite", 32'(fifo_write_o), 0);
            chk("full_hold", 32'(fifo_data_o), 32'h2211);
            step();
        end
        chk("full_count", 32'(nwrites), 32'(nw));
        fifo_full_i = 1'b0;
        step();
        chk("full_release", 32'(nwrites), 32'(nw + 1));
        step();
        step();
        chk("full_single", 32'(nwrites), 32'(nw + 1));

        // Reset while in HI discards the captured half
        q0.push_back(8'h33);
        q0.push_back(8'h44);
        nw = nwrites;
        drive();
        step();
        step();
        chk("hi_ready", 32'(req0_ready_o), 1);
        reset_ni = 1'b0;
        step();
        reset_ni = 1'b1;
        q0.delete();
        drive();
        chk("midrst_grant", 32'(grant_o), 0);
        chk("midrst_data", 32'(fifo_data_o), 0);
        chk("midrst_ready", 32'(req0_ready_o), 0);
        step();
        chk("midrst_nowrite", 32'(nwrites), 32'(nw));
        push_pair(0, 8'h55, 8'h66);
        drive();
        wait_writes(nwrites + 1, 20);

        // Partial pair
        q0.push_back(8'h5C);
        nw = nwrites;
        t0 = cyc;
        drive();
`ifdef PAIR_FLUSH_EN
        e.data = 16'h005C;
        e.gnt  = 2'b01;
        exp_q.push_back(e);
        wait_writes(nw + 1, 40);
        chk("flush_latency", 32'(last_wr_cyc - t0), 7);
`else
        for (int i = 0; i < 50; i++) step();
        chk("noflush_count", 32'(nwrites), 32'(nw));
        chk("noflush_grant", 32'(grant_o), 32'h1);
`endif
        chk("final_sb_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
